// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream boot loader that writes 16-bit words into instruction memory
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  load_count
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, COUNT, HI, LO, CHECK, DONE, ERROR
  } state_t;

  state_t          state, next_state;
  logic [7:0]      word_cnt;
  logic [7:0]      word_idx;
  logic [7:0]      hi_byte;
  logic [7:0]      checksum;
  logic [IW-1:0]   idle_cnt;
  logic            accept;
  logic            active;
  logic            timed_out;

  assign in_ready  = !reset && (state != DONE) && (state != ERROR);
  assign accept    = in_valid && in_ready;
  assign active    = (state == COUNT) || (state == HI) || (state == LO) || (state == CHECK);
  // The error edge is the one on which the idle counter would reach TIMEOUT.
  assign timed_out = active && !accept && (idle_cnt == IW'(TIMEOUT - 1));

  assign done      = (state == DONE);
  assign err       = (state == ERROR);
  assign cpu_reset = (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (timed_out) begin
      next_state = ERROR;
    end else if (accept) begin
      case (state)
        IDLE:    if (in_data == SYNC_BYTE) next_state = COUNT;
        COUNT:   next_state = (in_data == 8'd0) ? ERROR : HI;
        HI:      next_state = LO;
        LO:      next_state = ((word_idx + 8'd1) == word_cnt) ? CHECK : HI;
        CHECK:   next_state = (in_data == checksum) ? DONE : ERROR;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      err_code   <= 2'd0;
      load_count <= 8'd0;
      word_cnt   <= 8'd0;
      word_idx   <= 8'd0;
      hi_byte    <= 8'd0;
      checksum   <= 8'd0;
      idle_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;

      if (active && !accept) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      if (timed_out) begin
        err_code <= 2'd3;
      end else if (accept) begin
        case (state)
          COUNT: begin
            if (in_data == 8'd0) begin
              err_code <= 2'd1;
            end else begin
              word_cnt <= in_data;
              word_idx <= 8'd0;
              checksum <= 8'd0;
            end
          end
          HI: begin
            hi_byte  <= in_data;
            checksum <= checksum ^ in_data;
          end
          LO: begin
            mem_we     <= 1'b1;
            mem_addr   <= {8'h00, word_idx};
            mem_wdata  <= {hi_byte, in_data};
            checksum   <= checksum ^ in_data;
            word_idx   <= word_idx + 8'd1;
            load_count <= load_count + 8'd1;
          end
          CHECK: begin
            if (in_data != checksum) err_code <= 2'd2;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized frame bench for program_loader with a frame-level reference model
module tb_program_loader;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  load_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_wr[$];
  logic [31:0] exp_wr[$];
  logic        exp_done;
  logic [1:0]  exp_code;
  logic [7:0]  fr[$];

  program_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err), .err_code(err_code),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) got_wr.push_back({mem_addr, mem_wdata});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = $urandom_range(maxgap, 0);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    chk("ready_at_send", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  // Whole-frame view: skip to sync, read count, pair bytes into words, XOR all data bytes.
  task automatic model(input logic [7:0] bs[$]);
    int i;
    int n;
    logic [7:0] x;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_code = 2'd0;
    x = 8'h00;
    i = 0;
    while (i < bs.size() && bs[i] != 8'hA5) i++;
    i++;
    n = int'(bs[i]);
    i++;
    if (n == 0) begin
      exp_code = 2'd1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_wr.push_back({8'h00, 8'(w), bs[i], bs[i+1]});
      x = x ^ bs[i] ^ bs[i+1];
      i += 2;
    end
    if (bs[i] == x) exp_done = 1'b1;
    else exp_code = 2'd2;
  endtask

  task automatic run_frame(input logic [7:0] bs[$], input bit rst, input string tag, input int maxgap);
    if (rst) do_reset();
    got_wr.delete();
    model(bs);
    foreach (bs[k]) send_byte(bs[k], maxgap);
    @(negedge clk);
    chk({tag, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    foreach (exp_wr[k])
      chk({tag, "_wr"}, (k < got_wr.size()) ? got_wr[k] : 32'hFFFF_FFFF, exp_wr[k]);
    chk({tag, "_load_count"}, 32'(load_count), 32'(exp_wr.size()));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(exp_code != 2'd0));
    chk({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] x;
    logic [7:0] v;

    // Reset held two cycles: every output at its reset value, then ready right after release.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame(fr, 1'b0, "good2", 3);

    fr = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_frame(fr, 1'b1, "badsum", 3);

    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'hBE, 8'hEF, 8'h51};
    run_frame(fr, 1'b1, "junk", 2);

    fr = '{8'hA5, 8'h00};
    run_frame(fr, 1'b1, "zero", 2);

    // Timeout: the error lands exactly TO idle cycles after the last accepted byte.
    do_reset();
    got_wr.delete();
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    send_byte(8'h12, 2);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("to_err_early", 32'(err), 32'd0);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_err_code", 32'(err_code), 32'd3);
    chk("to_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("to_done", 32'(done), 32'd0);
    chk("to_nwr", 32'(got_wr.size()), 32'd0);

    // Reset mid-frame, with a byte offered on the reset edge.
    do_reset();
    got_wr.delete();
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hAB;
    @(negedge clk);
    chk("mid_load_count", 32'(load_count), 32'd0);
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_ready_rel", 32'(in_ready), 32'd1);
    chk("mid_nwr", 32'(got_wr.size()), 32'd1);
    fr = '{8'hA5, 8'h01, 8'hC0, 8'hDE, 8'h1E};
    run_frame(fr, 1'b0, "fresh", 2);

    for (int r = 0; r < 8; r++) begin
      fr.delete();
      repeat ($urandom_range(3, 0)) begin
        v = 8'($urandom);
        if (v == 8'hA5) v = 8'h5A;
        fr.push_back(v);
      end
      n = (r == 5) ? 0 : int'($urandom_range(6, 1));
      fr.push_back(8'hA5);
      fr.push_back(8'(n));
      if (n != 0) begin
        x = 8'h00;
        for (int k = 0; k < 2 * n; k++) begin
          v = 8'($urandom);
          x ^= v;
          fr.push_back(v);
        end
        if ($urandom_range(2, 0) == 0) x ^= 8'($urandom_range(255, 1));
        fr.push_back(x);
      end
      run_frame(fr, 1'b1, "rnd", 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, the maximum number of cycles allowed between accepted bytes inside a frame.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  the upstream byte source has a byte on in_data.
REQ-006 The block SHALL have port in_data  input  8  the incoming byte.
REQ-007 The block SHALL have port in_ready  output  1  the loader can accept a byte this cycle.
REQ-008 The block SHALL have port mem_we  output  1  write strobe to the instruction memory.
REQ-009 The block SHALL have port mem_addr  output  16  instruction word address, in the same address space as the PC.
REQ-010 The block SHALL have port mem_wdata  output  16  instruction word to write.
REQ-011 The block SHALL have port cpu_reset  output  1  holds the CPU core in reset while loading.
REQ-012 The block SHALL have port done  output  1  the load completed and was verified.
REQ-013 The block SHALL have port err  output  1  the load failed.
REQ-014 The block SHALL have port err_code  output  2  failure cause: 0 none, 1 zero count, 2 checksum, 3 timeout.
REQ-015 The block SHALL have port load_count  output  8  number of words written so far.

Function
REQ-016 A byte SHALL be accepted on a rising edge where in_valid && in_ready; in_valid may drop between bytes with no effect other than the timeout.
REQ-017 in_ready SHALL be 0 while reset is high, 1 in IDLE/COUNT/HI/LO/CHECK, and 0 in DONE/ERROR.
REQ-018 The FSM states SHALL be IDLE, COUNT, HI, LO, CHECK, DONE and ERROR.
REQ-019 IDLE: an accepted byte equal to SYNC_BYTE SHALL move the FSM to COUNT; any other accepted byte SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-020 COUNT: an accepted byte N=0 SHALL move the FSM to ERROR with err_code=1; N in 1..255 SHALL be latched, with word index and checksum cleared to 0, and the FSM SHALL move to HI.
REQ-021 HI: the accepted byte SHALL be latched as the high byte, XORed into the checksum, and the FSM SHALL move to LO.
REQ-022 LO: on the accepted byte, mem_we SHALL be 1 for exactly the next cycle, with mem_addr = {8'h00, word index} and mem_wdata = {high byte, byte}.
REQ-023 LO (continued): on the same accepted byte, the checksum SHALL be XORed with the byte, the word index and load_count SHALL increment, and the FSM SHALL move to CHECK if the new index equals N, otherwise to HI.
REQ-024 CHECK: if the accepted byte equals the running XOR, the FSM SHALL move to DONE; otherwise it SHALL move to ERROR with err_code=2.
REQ-025 DONE SHALL set done=1 and cpu_reset=0 in the cycle after the checksum byte is accepted, and SHALL be sticky until reset.
REQ-026 ERROR SHALL set err=1 with err_code held, keep cpu_reset=1, and SHALL be sticky until reset; done and err SHALL never both be 1.
REQ-027 In COUNT/HI/LO/CHECK, an idle counter SHALL clear on every accepted byte and increment otherwise; reaching TIMEOUT SHALL move the FSM to ERROR with err_code=3.
REQ-028 The idle counter SHALL be inactive in IDLE, so the loader waits for SYNC_BYTE indefinitely.
REQ-029 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-030 cpu_reset SHALL be 1 in every state except DONE.

Reset
REQ-031 reset high at a rising edge SHALL force: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, done 0, err 0, err_code 0, load_count 0, idle counter 0, checksum 0.
REQ-032 reset SHALL take priority over any simultaneous byte acceptance; reset mid-frame SHALL abandon the frame with no further writes.

Verification
REQ-033 The bench SHALL cover: reset held 2 cycles -> all outputs at their REQ-031 values, in_ready=0, then in_ready=1 in the first cycle after release.
REQ-034 The bench SHALL cover: bytes A5 02 12 34 AB CD 40 with gaps -> writes (0x0000, 0x1234) and (0x0001, 0xABCD), load_count=2, then done=1, cpu_reset=0, in_ready=0.
REQ-035 The bench SHALL cover: the same frame with checksum 0x41 -> err=1, err_code=2, cpu_reset=1, done=0.
REQ-036 The bench SHALL cover: bytes 00 FF 5A then A5 01 BE EF 51 -> the first three bytes produce no writes; the frame writes (0x0000, 0xBEEF) and sets done=1.
REQ-037 The bench SHALL cover: A5 00 -> err_code=1 with no mem_we; and A5 01 12 followed by TIMEOUT idle cycles -> err_code=3.
REQ-038 The bench SHALL cover: reset asserted after A5 02 12 34 -> FSM in IDLE, load_count=0, and a fresh complete frame then loads correctly.
